// File: rtl/bitserial_pkg.sv
// bitserial_pkg
// Types and defaults shared by the bit-serial activation sequencer and its
// shift-accumulator. The FSM state enum, default geometry and the
// accumulator width helper live here.
package bitserial_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_e;

   localparam int DEF_N_LANES  = 32;
   localparam int DEF_ACT_BITS = 4;
   localparam int DEF_PSUM_W   = 8;
   localparam int DEF_PSUM_LAT = 1;

   // (2^ACT_BITS-1)*(2^PSUM_W-1) < 2^(PSUM_W+ACT_BITS), so this width never overflows.
   function automatic int acc_w(input int psum_w, input int act_bits);
      return psum_w + act_bits;
   endfunction

endpackage

// File: rtl/bitserial_shift_acc.sv
// bitserial_shift_acc
// Tags each plane driven to the MAC, delays the tag by the MAC latency,
// and shift-accumulates the returning partial sum. It also owns the
// result register.
// Optional feature macro: SIGNED_ACT_EN. When it is defined, the MSB plane is
// subtracted, so the result is the two's-complement dot product.
// Ports:
//   CLK, reset       clock, synchronous active-high reset
//   clr_i            clear accumulator (operation start edge)
//   tag_vld_i        a plane is being registered onto plane_out this edge
//   tag_idx_i        index k of that plane
//   psum_i           MAC partial sum for the plane issued PSUM_LAT cycles ago
//   last_o           final plane has been accumulated; result loads next edge
//   result_o         final dot product, held until the next result
//   result_valid_o   one-cycle pulse when result_o updates
module bitserial_shift_acc #(
   parameter int ACT_BITS = 4,
   parameter int PSUM_W   = 8,
   parameter int PSUM_LAT = 1,
   parameter int ACC_W    = PSUM_W + ACT_BITS,
   parameter int KW       = 2
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              tag_vld_i,
   input  logic [KW-1:0]     tag_idx_i,
   input  logic [PSUM_W-1:0] psum_i,
   output logic              last_o,
   output logic [ACC_W-1:0]  result_o,
   output logic              result_valid_o
);

   localparam logic [KW-1:0] K_LAST = KW'(ACT_BITS - 1);

   // Stage 0 is loaded on the same edge as plane_out. Stage PSUM_LAT then lines up with psum_i.
   logic [PSUM_LAT:0]         vld_pipe_q;
   logic [PSUM_LAT:0][KW-1:0] idx_pipe_q;
   logic [ACC_W-1:0]          acc_q, acc_d, term;
   logic                      last_q, last_d;
   logic [ACC_W-1:0]          result_q;
   logic                      result_valid_q;

   always_comb begin
      term   = ACC_W'(psum_i) << idx_pipe_q[PSUM_LAT];
      acc_d  = acc_q;
      last_d = vld_pipe_q[PSUM_LAT] && (idx_pipe_q[PSUM_LAT] == K_LAST);
      if (clr_i) begin
         acc_d = '0;
      end else if (vld_pipe_q[PSUM_LAT]) begin
`ifdef SIGNED_ACT_EN
         // The MSB plane carries weight -2^k in two's complement.
         if (idx_pipe_q[PSUM_LAT] == K_LAST) acc_d = acc_q - term;
         else                                acc_d = acc_q + term;
`else
         acc_d = acc_q + term;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         vld_pipe_q     <= '0;
         idx_pipe_q     <= '0;
         acc_q          <= '0;
         last_q         <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         vld_pipe_q[0] <= tag_vld_i;
         idx_pipe_q[0] <= tag_idx_i;
         for (int j = 1; j <= PSUM_LAT; j++) begin
            vld_pipe_q[j] <= vld_pipe_q[j-1];
            idx_pipe_q[j] <= idx_pipe_q[j-1];
         end
         acc_q          <= acc_d;
         last_q         <= last_d;
         result_valid_q <= last_q;
         if (last_q) result_q <= acc_q;
      end
   end

   assign last_o         = last_q;
   assign result_o       = result_q;
   assign result_valid_o = result_valid_q;

endmodule

// File: rtl/bitserial_act_sequencer.sv
// bitserial_act_sequencer
// Latches N_LANES multi-bit activations and streams them LSB-first as 1-bit
// planes to the MAC array, one plane per cycle. The returning partial sums
// are shift-accumulated into the full-precision dot product.
// Optional feature macro: SIGNED_ACT_EN, which selects two's-complement
// activations. The macro is handled inside bitserial_shift_acc.
// Ports:
//   CLK, reset     clock, synchronous active-high reset
//   start          begin an operation (ignored while busy)
//   act_data       lane i at [i*ACT_BITS +: ACT_BITS], captured at start edge
//   plane_out      registered activation bit plane to the MAC
//   psum_in        MAC partial sum, PSUM_LAT cycles behind plane_out
//   busy           high from the start edge until result_valid
//   result         final dot product, held until the next result
//   result_valid   one-cycle pulse when result updates
module bitserial_act_sequencer
   import bitserial_pkg::*;
#(
   parameter int N_LANES  = DEF_N_LANES,
   parameter int ACT_BITS = DEF_ACT_BITS,
   parameter int PSUM_W   = DEF_PSUM_W,
   parameter int PSUM_LAT = DEF_PSUM_LAT,
   parameter int ACC_W    = acc_w(DEF_PSUM_W, DEF_ACT_BITS)
) (
   input  logic                        CLK,
   input  logic                        reset,
   input  logic                        start,
   input  logic [N_LANES*ACT_BITS-1:0] act_data,
   output logic [N_LANES-1:0]          plane_out,
   input  logic [PSUM_W-1:0]           psum_in,
   output logic                        busy,
   output logic [ACC_W-1:0]            result,
   output logic                        result_valid
);

   localparam int            KW     = (ACT_BITS > 1) ? $clog2(ACT_BITS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(ACT_BITS - 1);

   state_e                      state_q;
   logic [N_LANES*ACT_BITS-1:0] act_q;
   logic [KW-1:0]               k_q;
   logic [N_LANES-1:0]          plane_q;
   logic                        busy_q;
   logic                        accept, tag_vld, last_acc;
   logic [KW-1:0]               tag_idx;

   function automatic logic [N_LANES-1:0] plane_sel(input logic [N_LANES*ACT_BITS-1:0] a,
                                                    input logic [KW-1:0] k);
      logic [N_LANES-1:0] p;
      p = '0;
      for (int i = 0; i < N_LANES; i++) p[i] = a[i*ACT_BITS + int'(k)];
      return p;
   endfunction

   // A plane is tagged on every edge that loads a real plane onto plane_out.
   always_comb begin
      accept  = (state_q == IDLE) && start;
      tag_vld = accept || (state_q == STREAM);
      tag_idx = accept ? '0 : k_q;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= IDLE;
         act_q   <= '0;
         k_q     <= '0;
         plane_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  act_q   <= act_data;
                  plane_q <= plane_sel(act_data, '0);
                  k_q     <= KW'(1);
                  busy_q  <= 1'b1;
                  state_q <= STREAM;
               end else begin
                  plane_q <= '0;
               end
            end
            STREAM: begin
               plane_q <= plane_sel(act_q, k_q);
               if (k_q == K_LAST) begin
                  k_q     <= '0;
                  state_q <= DRAIN;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            DRAIN: begin
               plane_q <= '0;
               // Leave on the same edge that loads the result register.
               if (last_acc) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   bitserial_shift_acc #(
      .ACT_BITS (ACT_BITS),
      .PSUM_W   (PSUM_W),
      .PSUM_LAT (PSUM_LAT),
      .ACC_W    (ACC_W),
      .KW       (KW)
   ) u_acc (
      .CLK            (CLK),
      .reset          (reset),
      .clr_i          (accept),
      .tag_vld_i      (tag_vld),
      .tag_idx_i      (tag_idx),
      .psum_i         (psum_in),
      .last_o         (last_acc),
      .result_o       (result),
      .result_valid_o (result_valid)
   );

   assign plane_out = plane_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bitserial_act_sequencer.sv
// tb_bitserial_act_sequencer
// Directed bench for the sequencer with a behavioural registered MAC
// (3b weights x 1b activations, 32 lanes) between plane_out and psum_in.
module tb_bitserial_act_sequencer;

   localparam int N  = 32;
   localparam int AB = 4;
   localparam int PW = 8;
   localparam int AW = 12;

   logic          CLK = 1'b0;
   logic          reset, start;
   logic [N*AB-1:0] act_data;
   logic [N-1:0]  plane_out;
   logic [PW-1:0] psum_in;
   logic          busy;
   logic [AW-1:0] result;
   logic          result_valid;

   logic [2:0]    w [N];
   int            n_chk = 0;
   int            n_err = 0;

   always #5 CLK = ~CLK;

   bitserial_act_sequencer dut (
      .CLK          (CLK),
      .reset        (reset),
      .start        (start),
      .act_data     (act_data),
      .plane_out    (plane_out),
      .psum_in      (psum_in),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid)
   );

   function automatic logic [PW-1:0] mac(input logic [N-1:0] p);
      int s = 0;
      for (int i = 0; i < N; i++) if (p[i]) s += int'(w[i]);
      return PW'(s);
   endfunction

   // The MAC registers once.
   always @(posedge CLK) begin
      if (reset) psum_in <= '0;
      else       psum_in <= mac(plane_out);
   end

   function automatic logic [AW-1:0] golden(input logic [N*AB-1:0] a);
      int s = 0;
      logic [AB-1:0] av;
      for (int i = 0; i < N; i++) begin
         av = a[i*AB +: AB];
`ifdef SIGNED_ACT_EN
         s += int'(w[i]) * int'($signed(av));
`else
         s += int'(w[i]) * int'(av);
`endif
      end
      return AW'(s);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_w(input int v);
      for (int i = 0; i < N; i++) w[i] = 3'(v);
   endtask

   function automatic logic [N*AB-1:0] all_act(input logic [AB-1:0] v);
      return {N{v}};
   endfunction

   // Call just after the start edge. lat is the edge count at which result_valid
   // is first seen, or 99 if it never appears.
   task automatic wait_rv(output int lat);
      lat = 99;
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         if (result_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [N*AB-1:0] a, input logic [AW-1:0] exp, input string tag);
      int lat;
      act_data = a;
      start    = 1'b1;
      @(negedge CLK);
      start    = 1'b0;
      act_data = ~a;
      chk({tag, "_busy"}, 32'(busy), 1);
      wait_rv(lat);
      chk({tag, "_lat"}, lat, 6);
      chk({tag, "_res"}, 32'(result), 32'(exp));
      chk({tag, "_busy_off"}, 32'(busy), 0);
   endtask

   initial begin
      logic [N*AB-1:0] a2;
      logic [4:0]      seq;
      int              npulse, lat, changed;

      reset = 1'b1; start = 1'b0; act_data = '0;
      set_w(0);
      repeat (3) @(negedge CLK);
      chk("rst_plane", 32'(plane_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_res", 32'(result), 0);
      chk("rst_rv", 32'(result_valid), 0);
      reset = 1'b0;
      @(negedge CLK);

      // T1: full-scale activations.
      set_w(7);
`ifdef SIGNED_ACT_EN
      run_op(all_act(4'hF), 12'hF20, "t1");
`else
      run_op(all_act(4'hF), 12'hD20, "t1");
`endif

      // T2: single lane, act = 5, weight = 3. Check the plane sequence.
      set_w(0); w[0] = 3'd3;
      a2 = '0; a2[3:0] = 4'd5;
      seq = 5'b00101;
      act_data = a2; start = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         @(negedge CLK);
         start = 1'b0;
         if (c <= 4) chk("t2_plane", 32'(plane_out), 32'(seq[c]));
         chk("t2_rv", 32'(result_valid), 32'(c == 6));
      end
      chk("t2_res", 32'(result), 15);

      // T3: start pulses mid-operation are ignored. Then start again in the result_valid cycle.
      set_w(1);
      act_data = all_act(4'd3); start = 1'b1;
      @(negedge CLK);
      npulse = 0;
      for (int c = 1; c <= 6; c++) begin
         start = (c == 2 || c == 4);
         @(negedge CLK);
         if (result_valid) npulse++;
      end
      start = 1'b0;
      chk("t3_rv", 32'(result_valid), 1);
      chk("t3_pulses", npulse, 1);
      chk("t3_res", 32'(result), 96);
      act_data = all_act(4'd1); start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("t3b_busy", 32'(busy), 1);
      changed = 0;
      lat = 99;
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         if (result_valid) begin
            lat = c;
            break;
         end
         if (result !== 12'd96) changed++;
      end
      chk("t3b_hold", changed, 0);
      chk("t3b_lat", lat, 6);
      chk("t3b_res", 32'(result), 32);

      // T4: reset in the middle of a stream.
      set_w(2);
      act_data = all_act(4'd6); start = 1'b1;
      @(negedge CLK); start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      reset = 1'b1;
      @(negedge CLK);
      chk("t4_plane", 32'(plane_out), 0);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_res", 32'(result), 0);
      chk("t4_rv", 32'(result_valid), 0);
      reset = 1'b0;
      @(negedge CLK);
      run_op(all_act(4'd6), 12'd384, "t4_fresh");

`ifdef SIGNED_ACT_EN
      // T5: signed activations.
      set_w(0); w[0] = 3'd3;
      a2 = '0; a2[3:0] = 4'b1111;
      run_op(a2, 12'hFFD, "t5_neg");
      a2[3:0] = 4'b0111;
      run_op(a2, 12'd21, "t5_pos");
`endif

      // T6: random vectors against the golden dot product.
      for (int n = 0; n < 200; n++) begin
         for (int i = 0; i < N; i++) w[i] = 3'($urandom_range(0, 7));
         a2 = {$urandom, $urandom, $urandom, $urandom};
         run_op(a2, golden(a2), "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
